johnson_step_ctrl: RTL
======================

JOHNSON_STEP_CTRL -- requirements
Module: johnson_step_ctrl

Interface
REQ-001 SHALL have parameter STEP_W, default 8, width of the step-count field.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_ready  output  1  command accepted this cycle when cmd_valid is also 1.
REQ-006 SHALL have port cmd_op  input  2  operation: 00 STEP, 01 CLEAR, 10/11 reserved (accepted, no action, DONE).
REQ-007 SHALL have port cmd_dir  input  1  1 = forward (out[3]<=~out[0], shift right), 0 = reverse (out[0]<=~out[3], shift left).
REQ-008 SHALL have port cmd_count  input  STEP_W  number of steps for STEP.
REQ-009 SHALL have port hold  input  1  pause stepping while in RUN.
REQ-010 SHALL have port abort  input  1  terminate a running STEP.
REQ-011 SHALL have port out  output  4  Johnson counter value.
REQ-012 SHALL have port busy  output  1  high in RUN.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port aborted  output  1  high with done when the command ended by abort.
REQ-015 SHALL have port err  output  1  one-cycle illegal-state pulse (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; cmd_ready SHALL equal (state==IDLE), combinationally.
REQ-017 Forward sequence from 0000 SHALL be 1000,1100,1110,1111,0111,0011,0001,0000; reverse SHALL be the exact inverse order.
REQ-018 On accept of STEP with cmd_count=N>0, SHALL latch dir and N, enter RUN; out SHALL change on each of the next N non-held edges.
REQ-019 In RUN, each edge with hold=0 and abort=0 SHALL perform one step and decrement remaining; the step taking remaining from 1 to 0 SHALL move the FSM to DONE.
REQ-020 In RUN with hold=1 and abort=0, out and remaining SHALL be unchanged.
REQ-021 In RUN with abort=1, SHALL perform no step, enter DONE, and set aborted; abort SHALL take priority over hold and over the final step.
REQ-022 STEP with cmd_count=0 SHALL go directly to DONE with out unchanged.
REQ-023 CLEAR SHALL load out=0000 on the accept edge and enter DONE.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE; aborted SHALL be 1 only in that cycle.
REQ-025 abort and hold SHALL be ignored in IDLE and DONE; cmd_valid SHALL be ignored outside IDLE.
REQ-026 Latency: STEP N with no hold SHALL give done in cycle N+1 after accept; back-to-back commands SHALL be spaced by at least one DONE cycle.

Reset
REQ-027 On reset low, asynchronously: out=0000, state=IDLE, remaining=0, busy=0, done=0, aborted=0, err=0; cmd_ready SHALL be 1.
REQ-028 Reset asserted mid-RUN SHALL discard the command without a done pulse.

Configuration
REQ-029 With JOHNSON_SELFCORRECT_EN defined, a RUN step from any of the 8 illegal out values SHALL load 0000 instead of shifting, pulse err for one cycle, and still decrement remaining.
REQ-030 Without JOHNSON_SELFCORRECT_EN, err SHALL be tied 0 and illegal values SHALL shift normally.

Structure
REQ-031 Package johnson_ctrl_pkg SHALL hold the op encodings, direction constants, FSM state encoding, and JOHNSON_W=4.
REQ-032 The shift register SHALL be sub-module johnson_core (ports clk, reset, en, dir, clr, out), with the FSM and step counter in johnson_step_ctrl.

Verification
REQ-033 Reset, then STEP dir=1 N=8 -> out 1000..0001,0000 on 8 consecutive edges; done pulses in cycle 9; busy is high for 8 cycles.
REQ-034 STEP dir=0 N=3 from 0000 -> out 0001,0011,0111; then CLEAR -> out=0000 and done in the next cycle.
REQ-035 STEP N=5 with hold=1 for 2 cycles after step 2 -> 5 steps completed, done at cycle 8; N=0 -> done at cycle 1 with out unchanged.
REQ-036 STEP N=10, abort=1 on the edge after step 4 (same cycle as hold=1) -> out frozen at step 4 value; done=1 and aborted=1 together for one cycle.
REQ-037 Reset pulsed low mid-RUN -> out=0000 immediately, no done, cmd_ready=1; the next command is accepted normally.
REQ-038 With JOHNSON_SELFCORRECT_EN, force out=0101 in RUN -> next step gives out=0000 and err pulses once; without the macro, err stays 0.

Source files
------------

// File: rtl/johnson_ctrl_pkg.sv
// Shared encodings for the Johnson step controller: op codes, direction,
// FSM state encoding and counter width.
package johnson_ctrl_pkg;

  localparam int JOHNSON_W = 4;

  typedef enum logic [1:0] {
    OP_STEP  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_RSVD2 = 2'b10,
    OP_RSVD3 = 2'b11
  } op_e;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // True for the 8 codes reachable from 0000 by Johnson shifting.
  function automatic logic johnson_legal(input logic [JOHNSON_W-1:0] v);
    logic ok;
    case (v)
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/johnson_core.sv
// 4-bit Johnson shift register: synchronous clear has priority over a
// single forward (shift right) or reverse (shift left) step.
module johnson_core
  import johnson_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 clr,
  output logic [JOHNSON_W-1:0] out
);

  logic [JOHNSON_W-1:0] out_q;
  logic [JOHNSON_W-1:0] out_d;

  // Next value: clear, one step in the requested direction, or hold.
  always_comb begin
    out_d = out_q;
    if (clr) begin
      out_d = '0;
    end else if (en) begin
      case (dir)
        DIR_FWD: out_d = {~out_q[0], out_q[JOHNSON_W-1:1]};
        DIR_REV: out_d = {out_q[JOHNSON_W-2:0], ~out_q[JOHNSON_W-1]};
        default: out_d = out_q;
      endcase
    end else begin
      out_d = out_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/johnson_step_ctrl.sv
// Command-driven Johnson counter stepper (IDLE/RUN/DONE FSM plus step count).
// Optional JOHNSON_SELFCORRECT_EN: illegal counter codes reload 0000 and pulse err.
module johnson_step_ctrl
  import johnson_ctrl_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic                 cmd_dir,
  input  logic [STEP_W-1:0]    cmd_count,
  input  logic                 hold,
  input  logic                 abort,
  output logic [JOHNSON_W-1:0] out,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 err
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   remaining_q, remaining_d;
  logic                dir_q, dir_d;
  logic                aborted_q, aborted_d;
  logic                core_en_s;
  logic                core_clr_s;
`ifdef JOHNSON_SELFCORRECT_EN
  logic                err_q, err_d;
`endif

  // Next-state, step-counter and core-control decode.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    aborted_d   = 1'b0;
    core_en_s   = 1'b0;
    core_clr_s  = 1'b0;
`ifdef JOHNSON_SELFCORRECT_EN
    err_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_STEP: begin
              dir_d       = cmd_dir;
              remaining_d = cmd_count;
              if (cmd_count != '0) begin
                state_d = ST_RUN;
              end else begin
                state_d = ST_DONE;
              end
            end
            OP_CLEAR: begin
              core_clr_s = 1'b1;
              state_d    = ST_DONE;
            end
            default: state_d = ST_DONE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Abort wins over hold and over the final step.
        if (abort) begin
          state_d     = ST_DONE;
          aborted_d   = 1'b1;
          remaining_d = '0;
        end else if (!hold) begin
          remaining_d = remaining_q - STEP_W'(1);
          if (remaining_q == STEP_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
`ifdef JOHNSON_SELFCORRECT_EN
          if (!johnson_legal(out)) begin
            core_clr_s = 1'b1;
            err_d      = 1'b1;
          end else begin
            core_en_s  = 1'b1;
          end
`else
          core_en_s = 1'b1;
`endif
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      dir_q       <= DIR_FWD;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      aborted_q   <= aborted_d;
    end
  end

`ifdef JOHNSON_SELFCORRECT_EN
  // Illegal-code pulse register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  johnson_core u_core (
    .clk   (clk),
    .reset (reset),
    .en    (core_en_s),
    .dir   (dir_q),
    .clr   (core_clr_s),
    .out   (out)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign aborted   = aborted_q;

endmodule
